// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order branch resolve queue feeding predictor feedback and fetch redirect
// Optional statistics counters are enabled by defining BRQ_STATS_EN.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [AW-1:0]              enq_pc,
    input  logic                       enq_pred_taken,
    input  logic [AW-1:0]              enq_pred_target,
    input  logic                       res_valid,
    output logic                       res_ready,
    input  logic                       res_taken,
    input  logic [AW-1:0]              res_target,
    input  logic                       flush,
    output logic                       feedback_valid,
    output logic [AW-1:0]              instrAddr_to_feedback,
    output logic                       feedback_branch_taken,
    output logic                       redirect_valid,
    output logic [AW-1:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]     count
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]                stat_resolved,
    output logic [31:0]                stat_mispredict
`endif
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    // Entry storage; contents are don't-care after reset, so no reset is applied.
    logic [AW-1:0] mem_pc_q          [DEPTH];
    logic          mem_pred_taken_q  [DEPTH];
    logic [AW-1:0] mem_pred_target_q [DEPTH];

    // Pointers carry an extra wrap bit above the index.
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;

    logic          feedback_valid_q, feedback_valid_d;
    logic [AW-1:0] feedback_addr_q, feedback_addr_d;
    logic          feedback_taken_q, feedback_taken_d;
    logic          redirect_valid_q, redirect_valid_d;
    logic [AW-1:0] redirect_pc_q, redirect_pc_d;

    logic          full;
    logic          empty;
    logic          enq_fire;
    logic          res_fire;
    logic [IW-1:0] head_idx;
    logic [IW-1:0] tail_idx;
    logic [AW-1:0] head_pc;
    logic          head_pred_taken;
    logic [AW-1:0] head_pred_target;
    logic          mispredict;

    assign head_idx = head_q[IW-1:0];
    assign tail_idx = tail_q[IW-1:0];

    assign full  = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);
    assign empty = (head_q == tail_q);

    // Flush blocks both handshakes; a full queue never bypasses on a same-cycle pop.
    assign enq_ready = !full && !flush;
    assign res_ready = !empty && !flush;

    assign enq_fire = enq_valid && enq_ready;
    assign res_fire = res_valid && res_ready;

    assign head_pc          = mem_pc_q[head_idx];
    assign head_pred_taken  = mem_pred_taken_q[head_idx];
    assign head_pred_target = mem_pred_target_q[head_idx];

    // A direction mismatch, or a taken/taken pair whose targets differ, is a mispredict.
    assign mispredict = (head_pred_taken != res_taken) ||
                        (head_pred_taken && res_taken && (head_pred_target != res_target));

    // Pointer update: flush empties to head, a mispredict keeps only the popped slot boundary.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (res_fire) begin
            head_d = head_q + PW'(1);
        end
        if (flush) begin
            tail_d = head_q;
        end else if (res_fire && mispredict) begin
            // Younger entries are wrong-path; a same-cycle enqueue is dropped too.
            tail_d = head_q + PW'(1);
        end else if (enq_fire) begin
            tail_d = tail_q + PW'(1);
        end
    end

    // Feedback and redirect strobes are registered one cycle after the resolve handshake.
    always_comb begin
        feedback_valid_d = res_fire;
        feedback_addr_d  = feedback_addr_q;
        feedback_taken_d = feedback_taken_q;
        redirect_valid_d = res_fire && mispredict;
        redirect_pc_d    = redirect_pc_q;
        if (res_fire) begin
            feedback_addr_d  = head_pc;
            feedback_taken_d = res_taken;
            if (mispredict) begin
                redirect_pc_d = res_taken ? res_target : (head_pc + AW'(4));
            end
        end
    end

    // Entry write at tail on every accepted enqueue.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem_pc_q[tail_idx]          <= enq_pc;
            mem_pred_taken_q[tail_idx]  <= enq_pred_taken;
            mem_pred_target_q[tail_idx] <= enq_pred_target;
        end
    end

    // Pointer and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q           <= '0;
            tail_q           <= '0;
            feedback_valid_q <= 1'b0;
            feedback_addr_q  <= '0;
            feedback_taken_q <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            feedback_valid_q <= feedback_valid_d;
            feedback_addr_q  <= feedback_addr_d;
            feedback_taken_q <= feedback_taken_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign feedback_valid        = feedback_valid_q;
    assign instrAddr_to_feedback = feedback_addr_q;
    assign feedback_branch_taken = feedback_taken_q;
    assign redirect_valid        = redirect_valid_q;
    assign redirect_pc           = redirect_pc_q;
    assign count                 = tail_q - head_q;

`ifdef BRQ_STATS_EN
    logic [31:0] stat_resolved_q, stat_resolved_d;
    logic [31:0] stat_mispredict_q, stat_mispredict_d;

    // Saturating event counters; flush does not touch them.
    always_comb begin
        stat_resolved_d   = stat_resolved_q;
        stat_mispredict_d = stat_mispredict_q;
        if (res_fire && (stat_resolved_q != 32'hFFFF_FFFF)) begin
            stat_resolved_d = stat_resolved_q + 32'd1;
        end
        if (res_fire && mispredict && (stat_mispredict_q != 32'hFFFF_FFFF)) begin
            stat_mispredict_d = stat_mispredict_q + 32'd1;
        end
    end

    // Counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved_q   <= '0;
            stat_mispredict_q <= '0;
        end else begin
            stat_resolved_q   <= stat_resolved_d;
            stat_mispredict_q <= stat_mispredict_d;
        end
    end

    assign stat_resolved   = stat_resolved_q;
    assign stat_mispredict = stat_mispredict_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - directed self-checking bench for branch_resolve_queue
module tb_branch_resolve_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 64;

    logic          clk;
    logic          rst_n;
    logic          enq_valid;
    logic          enq_ready;
    logic [AW-1:0] enq_pc;
    logic          enq_pred_taken;
    logic [AW-1:0] enq_pred_target;
    logic          res_valid;
    logic          res_ready;
    logic          res_taken;
    logic [AW-1:0] res_target;
    logic          flush;
    logic          feedback_valid;
    logic [AW-1:0] instrAddr_to_feedback;
    logic          feedback_branch_taken;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic [3:0]    count;
`ifdef BRQ_STATS_EN
    logic [31:0]   stat_resolved;
    logic [31:0]   stat_mispredict;
`endif

    int checks;
    int errors;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_pc;

    branch_resolve_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .enq_valid             (enq_valid),
        .enq_ready             (enq_ready),
        .enq_pc                (enq_pc),
        .enq_pred_taken        (enq_pred_taken),
        .enq_pred_target       (enq_pred_target),
        .res_valid             (res_valid),
        .res_ready             (res_ready),
        .res_taken             (res_taken),
        .res_target            (res_target),
        .flush                 (flush),
        .feedback_valid        (feedback_valid),
        .instrAddr_to_feedback (instrAddr_to_feedback),
        .feedback_branch_taken (feedback_branch_taken),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .count                 (count)
`ifdef BRQ_STATS_EN
        ,
        .stat_resolved         (stat_resolved),
        .stat_mispredict       (stat_mispredict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        enq_valid       = 1'b0;
        enq_pc          = '0;
        enq_pred_taken  = 1'b0;
        enq_pred_target = '0;
        res_valid       = 1'b0;
        res_taken       = 1'b0;
        res_target      = '0;
        flush           = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq_one(input logic [AW-1:0] pc, input logic pt, input logic [AW-1:0] tgt);
        enq_valid       = 1'b1;
        enq_pc          = pc;
        enq_pred_taken  = pt;
        enq_pred_target = tgt;
        step();
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_fb_valid", 64'(feedback_valid), 64'd0);
        chk("rst_fb_addr", instrAddr_to_feedback, 64'd0);
        chk("rst_fb_taken", 64'(feedback_branch_taken), 64'd0);
        chk("rst_rd_valid", 64'(redirect_valid), 64'd0);
        chk("rst_rd_pc", redirect_pc, 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_res_ready", 64'(res_ready), 64'd0);
        rst_n = 1'b1;
        step();

        // correctly predicted taken branch
        enq_one(64'h1000, 1'b1, 64'h1040);
        chk("t1_count1", 64'(count), 64'd1);
        chk("t1_res_ready", 64'(res_ready), 64'd1);
        res_valid  = 1'b1;
        res_taken  = 1'b1;
        res_target = 64'h1040;
        step();
        idle();
        chk("t1_fb_valid", 64'(feedback_valid), 64'd1);
        chk("t1_fb_addr", instrAddr_to_feedback, 64'h1000);
        chk("t1_fb_taken", 64'(feedback_branch_taken), 64'd1);
        chk("t1_rd_valid", 64'(redirect_valid), 64'd0);
        chk("t1_count0", 64'(count), 64'd0);
        step();
        chk("t1_fb_oneshot", 64'(feedback_valid), 64'd0);

        // direction mispredict discards younger entries and concurrent enqueue
        enq_one(64'h2000, 1'b1, 64'h2100);
        enq_one(64'h2004, 1'b0, 64'h0);
        enq_one(64'h2008, 1'b0, 64'h0);
        chk("t2_count3", 64'(count), 64'd3);
        res_valid       = 1'b1;
        res_taken       = 1'b0;
        enq_valid       = 1'b1;
        enq_pc          = 64'h200C;
        step();
        idle();
        chk("t2_fb_valid", 64'(feedback_valid), 64'd1);
        chk("t2_fb_addr", instrAddr_to_feedback, 64'h2000);
        chk("t2_fb_taken", 64'(feedback_branch_taken), 64'd0);
        chk("t2_rd_valid", 64'(redirect_valid), 64'd1);
        chk("t2_rd_pc", redirect_pc, 64'h2004);
        chk("t2_count0", 64'(count), 64'd0);
        step();
        chk("t2_rd_oneshot", 64'(redirect_valid), 64'd0);
        chk("t2_res_ready", 64'(res_ready), 64'd0);

        // taken/taken with wrong target
        enq_one(64'h3000, 1'b1, 64'h3100);
        res_valid  = 1'b1;
        res_taken  = 1'b1;
        res_target = 64'h3200;
        step();
        idle();
        chk("t3_fb_addr", instrAddr_to_feedback, 64'h3000);
        chk("t3_fb_taken", 64'(feedback_branch_taken), 64'd1);
        chk("t3_rd_valid", 64'(redirect_valid), 64'd1);
        chk("t3_rd_pc", redirect_pc, 64'h3200);
        chk("t3_count0", 64'(count), 64'd0);

        // fill to full, no bypass, then pairs across pointer wrap
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            enq_one(64'h4000 + 64'(4 * i), 1'b0, 64'h0);
            exp_q.push_back(64'h4000 + 64'(4 * i));
        end
        chk("t4_full_count", 64'(count), 64'd8);
        chk("t4_enq_ready0", 64'(enq_ready), 64'd0);
        res_valid = 1'b1;
        res_taken = 1'b0;
        enq_valid = 1'b1;
        enq_pc    = 64'h5000;
        step();
        idle();
        exp_pc = exp_q.pop_front();
        chk("t4_nobypass_count", 64'(count), 64'd7);
        chk("t4_nobypass_addr", instrAddr_to_feedback, exp_pc);
        chk("t4_nobypass_rd", 64'(redirect_valid), 64'd0);
        for (int k = 0; k < 20; k++) begin
            enq_valid = 1'b1;
            enq_pc    = 64'h6000 + 64'(4 * k);
            res_valid = 1'b1;
            res_taken = 1'b0;
            exp_q.push_back(64'h6000 + 64'(4 * k));
            step();
            idle();
            exp_pc = exp_q.pop_front();
            chk("t4_pair_addr", instrAddr_to_feedback, exp_pc);
            chk("t4_pair_count", 64'(count), 64'd7);
        end
        for (int k = 0; k < 7; k++) begin
            res_valid = 1'b1;
            res_taken = 1'b0;
            step();
            idle();
            exp_pc = exp_q.pop_front();
            chk("t4_drain_addr", instrAddr_to_feedback, exp_pc);
            chk("t4_drain_fb", 64'(feedback_valid), 64'd1);
        end
        chk("t4_empty", 64'(count), 64'd0);
        step();

        // flush with pending entries blocks both handshakes
        for (int i = 0; i < 5; i++) begin
            enq_one(64'h7000 + 64'(4 * i), 1'b1, 64'h7800);
        end
        chk("t5_count5", 64'(count), 64'd5);
        flush     = 1'b1;
        res_valid = 1'b1;
        res_taken = 1'b0;
        enq_valid = 1'b1;
        enq_pc    = 64'h7100;
        #1;
        chk("t5_res_ready0", 64'(res_ready), 64'd0);
        chk("t5_enq_ready0", 64'(enq_ready), 64'd0);
        step();
        idle();
        chk("t5_count0", 64'(count), 64'd0);
        chk("t5_fb_valid0", 64'(feedback_valid), 64'd0);
        chk("t5_rd_valid0", 64'(redirect_valid), 64'd0);

        // asynchronous reset while strobes are high
        enq_one(64'h8000, 1'b0, 64'h0);
        enq_one(64'h8004, 1'b0, 64'h0);
        res_valid  = 1'b1;
        res_taken  = 1'b1;
        res_target = 64'h8800;
        step();
        idle();
        chk("t6_rd_before", 64'(redirect_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_count", 64'(count), 64'd0);
        chk("t6_async_fb", 64'(feedback_valid), 64'd0);
        chk("t6_async_rd", 64'(redirect_valid), 64'd0);
        chk("t6_async_rdpc", redirect_pc, 64'd0);
        step();
        rst_n = 1'b1;
        step();

`ifdef BRQ_STATS_EN
        // 10 resolves, every third one (3 total) a direction mispredict
        for (int i = 0; i < 10; i++) begin
            enq_one(64'h9000 + 64'(4 * i), 1'b0, 64'h0);
            res_valid = 1'b1;
            res_taken = (i % 3 == 2);
            step();
            idle();
        end
        chk("stat_resolved", 64'(stat_resolved), 64'd10);
        chk("stat_mispredict", 64'(stat_mispredict), 64'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
